// File: rtl/multdiv_sequencer_pkg.sv
// rtl/multdiv_sequencer_pkg.sv - state encodings and step-count defaults shared with the datapath
package multdiv_sequencer_pkg;

    localparam int DEF_N_CYCLES = 32;
    localparam int DEF_COUNT_W  = 6;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_LOAD = 2'd1;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/multdiv_sequencer_cells.sv
// rtl/multdiv_sequencer_cells.sv - toggle flop and enabled D flop with asynchronous clear
module tff (
    input  logic clk,
    input  logic clr,
    input  logic t,
    output logic q
);
    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q ^ t;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

module dffe_ref (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);
    logic q_q;
    logic q_d;

    always_comb begin
        q_d = en ? d : q_q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - load/run/done control for the iterative multiply/divide datapath
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int N_CYCLES = DEF_N_CYCLES,
    parameter int COUNT_W  = DEF_COUNT_W
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               ctrl_MULT,
    input  logic               ctrl_DIV,
    output logic               load,
    output logic               step_en,
    output logic               op_is_div,
    output logic [COUNT_W-1:0] count,
    output logic               data_resultRDY
);
    localparam logic [COUNT_W-1:0] LAST_IDX = COUNT_W'(N_CYCLES - 1);

    logic               start;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               op_is_div_q;
    logic               op_is_div_d;
    logic               terminal;
    logic               inc;
    logic [COUNT_W-1:0] carry;
    logic [COUNT_W-1:0] toggle;

    assign start    = ctrl_MULT | ctrl_DIV;
    assign terminal = (count == LAST_IDX);
    assign inc      = (state_q == ST_RUN) && !terminal;

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: state_d = ST_RUN;
                ST_RUN:  state_d = terminal ? ST_DONE : ST_RUN;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // MULT wins when both start pulses arrive together
    always_comb begin
        op_is_div_d = op_is_div_q;
        if (start) begin
            op_is_div_d = ctrl_DIV & ~ctrl_MULT;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            op_is_div_q <= 1'b0;
        end else begin
            op_is_div_q <= op_is_div_d;
        end
    end

    genvar gs;
    generate
        for (gs = 0; gs < STATE_W; gs++) begin : g_state
            dffe_ref u_state_bit (
                .clk (clock),
                .clr (clear),
                .en  (1'b1),
                .d   (state_d[gs]),
                .q   (state_q[gs])
            );
        end
    endgenerate

    // Ripple carry of the up-counter; in LOAD each bit toggles iff it is set, zeroing the count
    always_comb begin
        carry  = '0;
        toggle = '0;
        carry[0] = inc;
        for (int i = 1; i < COUNT_W; i++) begin
            carry[i] = carry[i-1] & count[i-1];
        end
        for (int i = 0; i < COUNT_W; i++) begin
            toggle[i] = (state_q == ST_LOAD) ? count[i] : carry[i];
        end
    end

    genvar gc;
    generate
        for (gc = 0; gc < COUNT_W; gc++) begin : g_count
            tff u_count_bit (
                .clk (clock),
                .clr (clear),
                .t   (toggle[gc]),
                .q   (count[gc])
            );
        end
    endgenerate

    assign load           = (state_q == ST_LOAD);
    assign step_en        = (state_q == ST_RUN);
    assign data_resultRDY = (state_q == ST_DONE);
    assign op_is_div      = op_is_div_q;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - directed bench for multdiv_sequencer at default and minimum step counts
module tb_multdiv_sequencer;
    logic       clock;
    logic       clear;
    logic       ctrl_MULT;
    logic       ctrl_DIV;
    logic       load;
    logic       step_en;
    logic       op_is_div;
    logic [5:0] count;
    logic       data_resultRDY;

    logic       ctrl2_MULT;
    logic       ctrl2_DIV;
    logic       load2;
    logic       step_en2;
    logic       op_is_div2;
    logic [0:0] count2;
    logic       data_resultRDY2;

    int vectors;
    int miscompares;

    multdiv_sequencer dut (
        .clock          (clock),
        .clear          (clear),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .load           (load),
        .step_en        (step_en),
        .op_is_div      (op_is_div),
        .count          (count),
        .data_resultRDY (data_resultRDY)
    );

    multdiv_sequencer #(.N_CYCLES(1), .COUNT_W(1)) dut1 (
        .clock          (clock),
        .clear          (clear),
        .ctrl_MULT      (ctrl2_MULT),
        .ctrl_DIV       (ctrl2_DIV),
        .load           (load2),
        .step_en        (step_en2),
        .op_is_div      (op_is_div2),
        .count          (count2),
        .data_resultRDY (data_resultRDY2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] snap();
        return {20'b0, load, step_en, op_is_div, data_resultRDY, 2'b0, count};
    endfunction

    function automatic logic [31:0] snap1();
        return {27'b0, load2, step_en2, op_is_div2, data_resultRDY2, count2};
    endfunction

    function automatic logic [31:0] exp_v(input logic l, input logic s, input logic o,
                                          input logic r, input int c);
        return {20'b0, l, s, o, r, 2'b0, 6'(c)};
    endfunction

    function automatic logic [31:0] exp_v1(input logic l, input logic s, input logic o,
                                           input logic r, input int c);
        return {27'b0, l, s, o, r, 1'(c)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse a start for one edge and confirm the LOAD cycle that follows
    task automatic start_op(input logic m, input logic d, input logic exp_op);
        ctrl_MULT = m;
        ctrl_DIV  = d;
        tick();
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        check("load_cycle", snap() & 32'hF00, exp_v(1, 0, exp_op, 0, 0) & 32'hF00);
    endtask

    task automatic expect_run(input logic exp_op);
        for (int k = 0; k < 32; k++) begin
            tick();
            check($sformatf("run_k%0d", k), snap(), exp_v(0, 1, exp_op, 0, k));
        end
        tick();
        check("done", snap(), exp_v(0, 0, exp_op, 1, 31));
        tick();
        check("idle_after", snap(), exp_v(0, 0, exp_op, 0, 31));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear       = 1'b1;
        ctrl2_MULT  = 1'b0;
        ctrl2_DIV   = 1'b0;
        ctrl_MULT   = 1'b0;
        ctrl_DIV    = 1'b0;

        for (int i = 0; i < 4; i++) begin
            ctrl_MULT = 1'($urandom);
            ctrl_DIV  = 1'($urandom);
            tick();
            check("reset", snap(), exp_v(0, 0, 0, 0, 0));
        end
        check("reset_n1", snap1(), exp_v1(0, 0, 0, 0, 0));
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        clear     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_hold", snap(), exp_v(0, 0, 0, 0, 0));
        end

        start_op(1'b1, 1'b0, 1'b0);
        expect_run(1'b0);

        start_op(1'b0, 1'b1, 1'b1);
        expect_run(1'b1);

        start_op(1'b1, 1'b1, 1'b0);
        expect_run(1'b0);

        ctrl_DIV = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_start", snap() & 32'hF00, exp_v(1, 0, 1, 0, 0) & 32'hF00);
        end
        ctrl_DIV = 1'b0;
        expect_run(1'b1);

        start_op(1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= 17; k++) begin
            tick();
        end
        check("pre_restart", snap(), exp_v(0, 1, 0, 0, 17));
        start_op(1'b0, 1'b1, 1'b1);
        expect_run(1'b1);

        start_op(1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= 9; k++) begin
            tick();
        end
        check("pre_clear", snap(), exp_v(0, 1, 0, 0, 9));
        #2 clear = 1'b1;
        #1 check("async_clear", snap(), exp_v(0, 0, 0, 0, 0));
        clear = 1'b0;
        begin
            int rdy_seen;
            rdy_seen = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (data_resultRDY) rdy_seen++;
            end
            check("no_rdy_after_clear", 32'(rdy_seen), 32'd0);
        end
        start_op(1'b0, 1'b1, 1'b1);
        expect_run(1'b1);

        ctrl2_MULT = 1'b1;
        tick();
        ctrl2_MULT = 1'b0;
        check("n1_load", snap1() & 32'h1E, exp_v1(1, 0, 0, 0, 0) & 32'h1E);
        tick();
        check("n1_run", snap1(), exp_v1(0, 1, 0, 0, 0));
        tick();
        check("n1_done", snap1(), exp_v1(0, 0, 0, 1, 0));
        tick();
        check("n1_idle", snap1(), exp_v1(0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
